upcounter_core: RTL and testbench

Tick-driven decimal up-counter that consumes the 1-cycle `tick` strobe from the upstream tick generator (one strobe per 1,000,001 clk). Provides run/stop and clear control through single-cycle command pulses. Each count update is published through a valid/ready port to the downstream SPI transmit stage, which frames it for the LED board.

---
 rtl/upcounter_core.sv | 97 +++++++++
 tb/tb_upcounter_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upcounter_core.sv
// Tick-driven decimal up-counter with run/stop/clear control.
// Each count update is published as a latest-value word on a valid/ready port.
module upcounter_core #(
  parameter int MAX_COUNT = 9999,
  parameter int CNT_W     = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             i_run_stop,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic             o_running,
  output logic [CNT_W+1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             o_overrun
);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] count_next;
  logic             wrap;
  logic             ev;
  logic [CNT_W+1:0] word;

  always_comb begin
    state_next = state;
    count_next = o_count;
    wrap       = 1'b0;
    ev         = 1'b0;
    case (state)
      ST_STOP: begin
        if (i_clear)
          state_next = ST_CLEAR;
        else if (i_run_stop)
          state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_clear)
          state_next = ST_CLEAR;
        else if (i_run_stop)
          state_next = ST_STOP;
        // the tick still counts in the cycle a stop or clear is sampled
        if (tick) begin
          ev = 1'b1;
          if (o_count == MAX_C) begin
            wrap       = 1'b1;
            count_next = '0;
          end else begin
            count_next = o_count + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        ev         = 1'b1;
        count_next = '0;
        state_next = ST_STOP;
      end
      default: begin
        state_next = ST_STOP;
      end
    endcase
  end

  assign word = {(state_next == ST_RUN), wrap, count_next};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_STOP;
      o_count   <= '0;
      o_running <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_next;
      o_count   <= count_next;
      o_running <= (state_next == ST_RUN);
      if (ev) begin
        tx_data  <= word;
        tx_valid <= 1'b1;
        if (tx_valid && !tx_ready)
          o_overrun <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_upcounter_core.sv
// Bench for upcounter_core: vector table, directed corner sequences,
// and random stimulus against a behavioural model.
module tb_upcounter_core;

  localparam int MAX = 9999;
  localparam int CW  = 14;

  logic          clk;
  logic          reset;
  logic          tick;
  logic          i_run_stop;
  logic          i_clear;
  logic [CW-1:0] o_count;
  logic          o_running;
  logic [CW+1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          o_overrun;

  upcounter_core #(.MAX_COUNT(MAX), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .i_run_stop(i_run_stop),
    .i_clear(i_clear),
    .o_count(o_count),
    .o_running(o_running),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .o_overrun(o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // model state: plain flags and an integer count
  bit          m_run;
  bit          m_clr;
  int          m_cnt;
  bit          m_pend;
  logic [15:0] m_data;
  bit          m_ovr;

  typedef struct packed {
    logic        t;
    logic        rs;
    logic        c;
    logic        r;
    logic [13:0] cnt;
    logic        run;
    logic        vld;
    logic [15:0] data;
    logic        ovr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_run  = 0;
    m_clr  = 0;
    m_cnt  = 0;
    m_pend = 0;
    m_data = '0;
    m_ovr  = 0;
  endtask

  task automatic mdl_edge(input bit t, input bit rs, input bit c,
                          input bit r);
    bit ev;
    bit wr;
    bit nrun;
    bit nclr;
    int ncnt;
    ev   = 0;
    wr   = 0;
    nrun = m_run;
    nclr = 0;
    ncnt = m_cnt;
    if (m_clr) begin
      ev   = 1;
      ncnt = 0;
      nrun = 0;
    end else if (m_run) begin
      if (c) begin
        nclr = 1;
        nrun = 0;
      end else if (rs) begin
        nrun = 0;
      end
      if (t) begin
        ev   = 1;
        wr   = (m_cnt == MAX);
        ncnt = wr ? 0 : m_cnt + 1;
      end
    end else begin
      if (c)
        nclr = 1;
      else if (rs)
        nrun = 1;
    end
    if (ev) begin
      if (m_pend && !r)
        m_ovr = 1;
      m_pend = 1;
      m_data = {nrun, wr, 14'(ncnt)};
    end else if (m_pend && r) begin
      m_pend = 0;
    end
    m_run = nrun;
    m_clr = nclr;
    m_cnt = ncnt;
  endtask

  task automatic cmp_model();
    chk("m_count", 16'(o_count), 16'(m_cnt));
    chk("m_running", 16'(o_running), 16'(m_run));
    chk("m_valid", 16'(tx_valid), 16'(m_pend));
    chk("m_data", tx_data, m_data);
    chk("m_overrun", 16'(o_overrun), 16'(m_ovr));
  endtask

  task automatic step(input logic t, input logic rs, input logic c,
                      input logic r);
    tick       = t;
    i_run_stop = rs;
    i_clear    = c;
    tx_ready   = r;
    @(posedge clk);
    mdl_edge(t, rs, c, r);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    tick       = 1'b0;
    i_run_stop = 1'b0;
    i_clear    = 1'b0;
    tx_ready   = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 16'(o_count), 16'd0);
    chk("rst_running", 16'(o_running), 16'd0);
    chk("rst_valid", 16'(tx_valid), 16'd0);
    chk("rst_data", tx_data, 16'h0000);
    chk("rst_overrun", 16'(o_overrun), 16'd0);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;

    //           t  rs c  r  cnt  run vld data      ovr
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,14'd0,1'b1,1'b0,16'h0000,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,14'd1,1'b1,1'b1,16'h8001,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,14'd1,1'b1,1'b0,16'h8001,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,14'd2,1'b1,1'b1,16'h8002,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,14'd3,1'b1,1'b1,16'h8003,1'b1};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,14'd3,1'b1,1'b0,16'h8003,1'b1};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,14'd4,1'b0,1'b1,16'h0004,1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,14'd4,1'b0,1'b0,16'h0004,1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,14'd4,1'b0,1'b0,16'h0004,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,14'd0,1'b0,1'b1,16'h0000,1'b1};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,14'd0,1'b1,1'b1,16'h0000,1'b1};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b1,14'd0,1'b0,1'b0,16'h0000,1'b1};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,14'd0,1'b0,1'b1,16'h0000,1'b1};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,14'd0,1'b0,1'b1,16'h0000,1'b1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].t, tbl[i].rs, tbl[i].c, tbl[i].r);
      chk($sformatf("tbl%0d_count", i), 16'(o_count), 16'(tbl[i].cnt));
      chk($sformatf("tbl%0d_run", i), 16'(o_running), 16'(tbl[i].run));
      chk($sformatf("tbl%0d_valid", i), 16'(tx_valid), 16'(tbl[i].vld));
      chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].data);
      chk($sformatf("tbl%0d_ovr", i), 16'(o_overrun), 16'(tbl[i].ovr));
    end

    // spaced ticks with a ready sink
    do_reset();
    step(0, 1, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0, 1);
      chk("t1_count", 16'(o_count), 16'(k));
      chk("t1_data", tx_data, 16'h8000 | 16'(k));
      chk("t1_valid", 16'(tx_valid), 16'd1);
      step(0, 0, 0, 1);
      chk("t1_valid_drop", 16'(tx_valid), 16'd0);
      repeat (8) step(0, 0, 0, 1);
    end
    chk("t1_overrun", 16'(o_overrun), 16'd0);

    // run up to the wrap point
    repeat (9995) step(1, 0, 0, 1);
    chk("t2_pre", 16'(o_count), 16'd9998);
    step(1, 0, 0, 1);
    chk("t2_max", 16'(o_count), 16'd9999);
    chk("t2_max_data", tx_data, 16'hA70F);
    step(1, 0, 0, 1);
    chk("t2_wrap", 16'(o_count), 16'd0);
    chk("t2_wrap_data", tx_data, 16'hC000);

    // stop in the same cycle as a tick
    repeat (5) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    chk("t3_count", 16'(o_count), 16'd6);
    chk("t3_running", 16'(o_running), 16'd0);
    chk("t3_data", tx_data, 16'h0006);
    chk("t3_valid", 16'(tx_valid), 16'd1);
    repeat (3) step(1, 0, 0, 1);
    chk("t3_hold", 16'(o_count), 16'd6);
    chk("t3_novalid", 16'(tx_valid), 16'd0);

    // clear and run/stop together
    step(0, 1, 0, 1);
    repeat (36) step(1, 0, 0, 1);
    chk("t4_pre", 16'(o_count), 16'd42);
    step(0, 1, 1, 1);
    chk("t4_running", 16'(o_running), 16'd0);
    chk("t4_count_hold", 16'(o_count), 16'd42);
    step(0, 0, 0, 1);
    chk("t4_count", 16'(o_count), 16'd0);
    chk("t4_data", tx_data, 16'h0000);
    chk("t4_valid", 16'(tx_valid), 16'd1);
    step(0, 0, 0, 1);
    chk("t4_stopped", 16'(o_running), 16'd0);

    // backpressure overrun
    step(0, 1, 0, 1);
    repeat (7) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("t5_data8", tx_data, 16'h8008);
    chk("t5_ovr0", 16'(o_overrun), 16'd0);
    step(1, 0, 0, 0);
    chk("t5_data9", tx_data, 16'h8009);
    chk("t5_valid", 16'(tx_valid), 16'd1);
    chk("t5_ovr1", 16'(o_overrun), 16'd1);
    step(0, 0, 0, 1);
    chk("t5_drop", 16'(tx_valid), 16'd0);
    chk("t5_sticky", 16'(o_overrun), 16'd1);

    // asynchronous reset with a word pending
    repeat (290) step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("t6_pre", 16'(o_count), 16'd300);
    chk("t6_pre_valid", 16'(tx_valid), 16'd1);
    reset = 1'b1;
    #1;
    chk("t6_count", 16'(o_count), 16'd0);
    chk("t6_running", 16'(o_running), 16'd0);
    chk("t6_valid", 16'(tx_valid), 16'd0);
    chk("t6_data", tx_data, 16'h0000);
    chk("t6_ovr", 16'(o_overrun), 16'd0);
    mdl_reset();
    #1;
    reset = 1'b0;
    repeat (3) step(1, 0, 0, 1);
    chk("t6_idle", 16'(o_count), 16'd0);
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    chk("t6_resume", 16'(o_count), 16'd1);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      step(logic'($urandom_range(2) == 0),
           logic'($urandom_range(9) == 0),
           logic'($urandom_range(29) == 0),
           logic'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
